// File: rtl/axi_2_native_fifo.sv
// AXI4-Stream slave to native FIFO write-port adapter with a 2-entry skid buffer.
// tready depends only on registered occupancy and rst, never on m_native_full.
//
// state     | meaning
// ----------+------------------------------------------------
// OCC_EMPTY | no beat buffered; tready = 1, no push
// OCC_ONE   | head valid; accept and push may happen together
// OCC_TWO   | head and tail valid; tready = 0 until a push
module axi_2_native_fifo #(
    parameter int STDataWidth = 32,
    parameter int TidWidth    = 8,
    parameter int TdestWidth  = 8,
    parameter int PktCntWidth = 16
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic [TidWidth-1:0]    s_axis_tid,
    input  logic [TdestWidth-1:0]  s_axis_tdest,
    input  logic [STDataWidth-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [TidWidth-1:0]    m_native_tid,
    output logic [TdestWidth-1:0]  m_native_tdest,
    output logic [STDataWidth-1:0] m_native_tdata,
    output logic                   m_native_tlast,
    output logic                   m_native_wr_en,
    input  logic                   m_native_full,
    output logic [PktCntWidth-1:0] pkt_count
);

    localparam int EntryWidth = TidWidth + TdestWidth + STDataWidth + 1;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  occ_q;
    occ_t                  occ_d;
    logic                  accept;
    logic                  push;
    logic                  load_head;
    logic                  load_tail;
    logic                  shift_tail;
    logic [EntryWidth-1:0] beat_in;
    logic [EntryWidth-1:0] head_q;
    logic [EntryWidth-1:0] tail_q;

    assign beat_in = {s_axis_tid, s_axis_tdest, s_axis_tdata, s_axis_tlast};
    assign accept  = s_axis_tvalid & s_axis_tready;
    assign push    = m_native_wr_en;

    always_ff @(posedge aclk) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Next occupancy plus the head/tail load controls that go with each transition.
    always_comb begin
        occ_d      = occ_q;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        shift_tail = 1'b0;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    occ_d     = OCC_ONE;
                    load_head = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && push) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    occ_d     = OCC_TWO;
                    load_tail = 1'b1;
                end else if (push) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (push) begin
                    occ_d      = OCC_ONE;
                    shift_tail = 1'b1;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    always_comb begin
        s_axis_tready  = 1'b0;
        m_native_wr_en = 1'b0;
        if (!rst) begin
            s_axis_tready  = (occ_q != OCC_TWO);
            m_native_wr_en = (occ_q != OCC_EMPTY) && !m_native_full;
        end
    end

    // Payload registers carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge aclk) begin
        if (load_head) begin
            head_q <= beat_in;
        end else if (shift_tail) begin
            head_q <= tail_q;
        end
        if (load_tail) begin
            tail_q <= beat_in;
        end
    end

    assign {m_native_tid, m_native_tdest, m_native_tdata, m_native_tlast} = head_q;

    always_ff @(posedge aclk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (push && m_native_tlast) begin
            pkt_count <= pkt_count + PktCntWidth'(1);
        end
    end

endmodule

// File: tb/tb_axi_2_native_fifo.sv
// Directed bench for axi_2_native_fifo: a queue model predicts tready, wr_en,
// pushed beats and packet counts; a second instance uses a 2-bit packet counter.
module tb_axi_2_native_fifo;

    logic        aclk;
    logic        rst;
    logic [7:0]  s_tid;
    logic [7:0]  s_tdest;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        full;

    logic        tready_a, wr_en_a, tlast_a;
    logic [7:0]  tid_a, tdest_a;
    logic [31:0] tdata_a;
    logic [15:0] pkt_a;

    logic        tready_b, wr_en_b, tlast_b;
    logic [7:0]  tid_b, tdest_b;
    logic [31:0] tdata_b;
    logic [1:0]  pkt_b;

    axi_2_native_fifo dut (
        .aclk(aclk), .rst(rst),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(tready_a),
        .m_native_tid(tid_a), .m_native_tdest(tdest_a), .m_native_tdata(tdata_a),
        .m_native_tlast(tlast_a), .m_native_wr_en(wr_en_a), .m_native_full(full),
        .pkt_count(pkt_a)
    );

    axi_2_native_fifo #(.PktCntWidth(2)) dut_w2 (
        .aclk(aclk), .rst(rst),
        .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(tready_b),
        .m_native_tid(tid_b), .m_native_tdest(tdest_b), .m_native_tdata(tdata_b),
        .m_native_tlast(tlast_b), .m_native_wr_en(wr_en_b), .m_native_full(full),
        .pkt_count(pkt_b)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0]  id;
        logic [7:0]  dest;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [15:0] m_pkt;
    logic [1:0]  m_pkt2;
    int          vectors;
    int          miscompares;
    int          dut_pushes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then advance the model.
    task automatic step(input logic v, input logic l, input logic [31:0] d,
                        input logic f, input logic r, output logic acc);
        logic  exp_rdy;
        logic  exp_wr;
        beat_t b;
        beat_t nb;
        @(negedge aclk);
        s_tvalid = v;
        s_tlast  = l;
        s_tdata  = d;
        s_tid    = d[7:0];
        s_tdest  = d[15:8] ^ 8'hA5;
        full     = f;
        rst      = r;
        #1;
        exp_rdy = !r && (q.size() != 2);
        exp_wr  = !r && (q.size() != 0) && !f;
        check("tready", tready_a, exp_rdy);
        check("wr_en", wr_en_a, exp_wr);
        check("tready_w2", tready_b, exp_rdy);
        check("wr_en_w2", wr_en_b, exp_wr);
        check("pkt_count", pkt_a, m_pkt);
        check("pkt_count_w2", pkt_b, m_pkt2);
        if (wr_en_a) dut_pushes++;
        if (exp_wr) begin
            b = q[0];
            check("tdata", tdata_a, b.data);
            check("tid", tid_a, b.id);
            check("tdest", tdest_a, b.dest);
            check("tlast", tlast_a, b.last);
            check("tdata_w2", tdata_b, b.data);
        end
        acc = v && exp_rdy;
        if (r) begin
            q.delete();
            m_pkt  = '0;
            m_pkt2 = '0;
        end else begin
            if (exp_wr) begin
                if (b.last) begin
                    m_pkt  = m_pkt + 16'd1;
                    m_pkt2 = m_pkt2 + 2'd1;
                end
                void'(q.pop_front());
            end
            if (acc) begin
                nb.id   = d[7:0];
                nb.dest = d[15:8] ^ 8'hA5;
                nb.data = d;
                nb.last = l;
                q.push_back(nb);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        int          n;
        int          base;
        int          iter;
        logic [1:0]  seq6 [5];
        vectors     = 0;
        miscompares = 0;
        dut_pushes  = 0;
        m_pkt       = '0;
        m_pkt2      = '0;
        rst         = 1'b1;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = '0;
        s_tid       = '0;
        s_tdest     = '0;
        full        = 1'b0;

        // 1: reset then 8 back-to-back beats, one packet
        step(0, 0, 0, 0, 1, acc);
        step(0, 0, 0, 0, 1, acc);
        base = dut_pushes;
        for (int i = 0; i < 8; i++) step(1, (i == 7), i, 0, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        step(0, 0, 0, 0, 0, acc);
        check("t1_pushes", dut_pushes - base, 8);
        check("t1_pkt", pkt_a, 1);

        // 2: full held with tvalid held; two beats fill the buffer, then release
        n = 0;
        base = dut_pushes;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 100 + n, 1, 0, acc);
            if (acc) n++;
        end
        check("t2_accepts_full", n, 2);
        check("t2_no_push_full", dut_pushes - base, 0);
        iter = 0;
        while (n < 6 && iter < 50) begin
            step(1, (n == 5), 100 + n, 0, 0, acc);
            if (acc) n++;
            iter++;
        end
        check("t2_done", n, 6);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
        check("t2_pushes", dut_pushes - base, 6);
        check("t2_pkt", pkt_a, 2);

        // 3: full toggles every cycle during a 16-beat packet
        n = 0;
        iter = 0;
        base = dut_pushes;
        while (n < 16 && iter < 100) begin
            step(1, (n == 15), 32'h1000 + n, iter[0], 0, acc);
            if (acc) n++;
            iter++;
        end
        check("t3_done", n, 16);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
        check("t3_pushes", dut_pushes - base, 16);
        check("t3_pkt", pkt_a, 3);

        // 4: random tvalid gaps, FIFO never full
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 32'h2000 + n, 0, 0, acc);
            if (acc) n++;
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);

        // 5: reset mid-packet with two beats buffered
        step(1, 0, 32'h5000, 1, 0, acc);
        step(1, 0, 32'h5001, 1, 0, acc);
        step(1, 0, 32'h5002, 1, 0, acc);
        check("t5_stalled", tready_a, 0);
        step(1, 0, 32'h5002, 0, 1, acc);
        step(0, 0, 0, 0, 0, acc);
        check("t5_pkt_after_rst", pkt_a, 0);
        check("t5_ready_after_rst", tready_a, 1);
        check("t5_wr_after_rst", wr_en_a, 0);
        base = dut_pushes;
        for (int i = 0; i < 3; i++) step(1, (i == 2), 32'h6000 + i, 0, 0, acc);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, acc);
        check("t5_pushes", dut_pushes - base, 3);
        check("t5_pkt", pkt_a, 1);

        // 6: 2-bit packet counter wraps over five one-beat packets
        seq6[0] = 2'd1; seq6[1] = 2'd2; seq6[2] = 2'd3; seq6[3] = 2'd0; seq6[4] = 2'd1;
        step(0, 0, 0, 0, 1, acc);
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 32'h7000 + k, 0, 0, acc);
            step(0, 0, 0, 0, 0, acc);
            @(posedge aclk);
            #1;
            check("t6_pkt_w2", pkt_b, seq6[k]);
        end
        check("t6_pkt", pkt_a, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
